// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received word plus status out, valid/ready handshake.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  // master drives the line and consumes words; slave is the receiver
  modport master (
    output rx, ready,
    input  data, valid, frame_err, parity_err, overrun
  );

  modport slave (
    input  rx, ready,
    output data, valid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: mid-bit sampling, parity/stop checking, break hold-off,
// and a single-entry output register with valid/ready handshake and overrun flag.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               r_state;
  logic [1:0]           r_sync;
  logic                 r_armed;
  logic [CntW-1:0]      r_cnt;
  logic [BitW-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  logic w_rxs;
  logic w_sample;
  logic w_frame_err;
  logic w_parity_err;
  logic w_break;

  assign w_rxs       = r_sync[1];
  // start bit is sampled after half a bit, everything else one full bit later
  assign w_sample    = (r_state == StStart) ? (r_cnt == HalfLast) : (r_cnt == FullLast);
  assign w_frame_err = r_stop_err | ~w_rxs;
  assign w_break     = w_frame_err & (r_shift == '0);

  always_comb begin
    w_parity_err = 1'b0;
    if (PARITY == 1) begin
      w_parity_err = ~(^r_shift ^ r_par_bit);
    end else if (PARITY == 2) begin
      w_parity_err = ^r_shift ^ r_par_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_sync       <= 2'b11;
      r_armed      <= 1'b1;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.rx};

      // a word completing on this edge overrides the handshake below
      if (r_valid && bus.ready) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (r_state != StIdle) begin
        r_cnt <= w_sample ? '0 : r_cnt + CntW'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (!r_armed) begin
            if (w_rxs) r_armed <= 1'b1;
          end else if (!w_rxs) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          if (w_sample) begin
            if (w_rxs) begin
              r_state <= StIdle;
            end else begin
              r_state    <= StData;
              r_bit_cnt  <= '0;
              r_stop_err <= 1'b0;
            end
          end
        end
        StData: begin
          if (w_sample) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == DataLast) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != 0) ? StParity : StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + BitW'(1);
            end
          end
        end
        StParity: begin
          if (w_sample) begin
            r_par_bit <= w_rxs;
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_sample) begin
            if (r_bit_cnt == StopLast) begin
              r_state      <= StIdle;
              r_bit_cnt    <= '0;
              r_data       <= r_shift;
              r_frame_err  <= w_frame_err;
              r_parity_err <= w_parity_err;
              r_overrun    <= r_valid & ~bus.ready;
              r_valid      <= 1'b1;
              // a break holds off new starts until the line has gone idle again
              r_armed      <= ~w_break;
            end else begin
              r_stop_err <= w_frame_err;
              r_bit_cnt  <= r_bit_cnt + BitW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.valid      = r_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two configurations (8E1 and 7O2), frame-level reference model with
// arithmetic completion timing, per-cycle output comparison plus hand-computed checkpoints.
module tb_uart_rx;
  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0;
  logic rst_n1;

  uart_rx_if #(.DATA_BITS(8)) if0 ();
  uart_rx_if #(.DATA_BITS(7)) if1 ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n0),
    .bus  (if0)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n1),
    .bus  (if1)
  );

  typedef struct {
    int         u;
    int         cyc;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } word_t;

  word_t      pq[$];
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  bit         cmp_en = 1'b0;
  logic       m_valid[2];
  logic [8:0] m_data[2];
  logic       m_fe[2];
  logic       m_pe[2];
  logic       m_ovr[2];

  function automatic int db(input int u);
    return (u == 0) ? 8 : 7;
  endfunction
  function automatic int par(input int u);
    return (u == 0) ? 2 : 1;
  endfunction
  function automatic int sb(input int u);
    return (u == 0) ? 1 : 2;
  endfunction
  function automatic int nsamp(input int u);
    return 1 + db(u) + ((par(u) != 0) ? 1 : 0) + sb(u);
  endfunction

  function automatic logic dut_valid(input int u);
    return (u == 0) ? if0.valid : if1.valid;
  endfunction
  function automatic logic [8:0] dut_data(input int u);
    return (u == 0) ? {1'b0, if0.data} : {2'b00, if1.data};
  endfunction
  function automatic logic dut_fe(input int u);
    return (u == 0) ? if0.frame_err : if1.frame_err;
  endfunction
  function automatic logic dut_pe(input int u);
    return (u == 0) ? if0.parity_err : if1.parity_err;
  endfunction
  function automatic logic dut_ovr(input int u);
    return (u == 0) ? if0.overrun : if1.overrun;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line samples for one frame: start, data LSB first, optional parity, stop bits.
  function automatic logic [15:0] mk(input int u, input logic [8:0] d, input bit bad_par,
                                     input bit bad_stop);
    logic [15:0] s;
    int          idx;
    int          ones;
    s    = '1;
    s[0] = 1'b0;
    ones = 0;
    for (int k = 0; k < db(u); k++) begin
      s[1+k] = d[k];
      if (d[k]) ones++;
    end
    idx = 1 + db(u);
    if (par(u) != 0) begin
      // even parity: total ones even; odd parity: total ones odd
      s[idx] = ((par(u) == 2) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ bad_par;
      idx++;
    end
    for (int k = 0; k < sb(u); k++) s[idx+k] = ~bad_stop;
    return s;
  endfunction

  task automatic push_expect(input int u, input logic [15:0] s, input int n);
    word_t w;
    int    ones;
    int    idx;
    w.u    = u;
    w.cyc  = n + 3 + OS / 2 + (nsamp(u) - 1) * OS;
    w.data = '0;
    ones   = 0;
    for (int k = 0; k < db(u); k++) begin
      w.data[k] = s[1+k];
      if (s[1+k]) ones++;
    end
    idx  = 1 + db(u);
    w.pe = 1'b0;
    if (par(u) != 0) begin
      if (s[idx]) ones++;
      w.pe = (par(u) == 2) ? (ones % 2 != 0) : (ones % 2 == 0);
      idx++;
    end
    w.fe = 1'b0;
    for (int k = 0; k < sb(u); k++) if (!s[idx+k]) w.fe = 1'b1;
    pq.push_back(w);
  endtask

  task automatic set_rx(input int u, input logic v);
    if (u == 0) if0.rx = v;
    else if1.rx = v;
  endtask

  task automatic set_rst(input int u, input logic v);
    if (u == 0) rst_n0 = v;
    else rst_n1 = v;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a negedge; the line falls immediately.
  task automatic send(input int u, input logic [15:0] s, input int tail_low);
    push_expect(u, s, cyc);
    for (int k = 0; k < nsamp(u); k++) begin
      set_rx(u, s[k]);
      repeat (OS) @(negedge clk);
    end
    repeat (tail_low) @(negedge clk);
    set_rx(u, 1'b1);
  endtask

  task automatic model_edge(input int u);
    logic rst;
    logic rdy;
    int   idx;
    rst = (u == 0) ? rst_n0 : rst_n1;
    rdy = (u == 0) ? if0.ready : if1.ready;
    if (!rst) begin
      m_valid[u] = 1'b0;
      m_data[u]  = '0;
      m_fe[u]    = 1'b0;
      m_pe[u]    = 1'b0;
      m_ovr[u]   = 1'b0;
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].u == u) pq.delete(i);
    end else begin
      idx = -1;
      foreach (pq[i]) if (pq[i].u == u && pq[i].cyc == cyc) idx = i;
      if (idx >= 0) begin
        m_ovr[u]   = m_valid[u] && !rdy;
        m_valid[u] = 1'b1;
        m_data[u]  = pq[idx].data;
        m_fe[u]    = pq[idx].fe;
        m_pe[u]    = pq[idx].pe;
        pq.delete(idx);
      end else if (m_valid[u] && rdy) begin
        m_valid[u] = 1'b0;
        m_ovr[u]   = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int u = 0; u < 2; u++) model_edge(u);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d_outputs", u),
              {19'd0, dut_valid(u), dut_data(u), dut_fe(u), dut_pe(u), dut_ovr(u)},
              {19'd0, m_valid[u], m_data[u], m_fe[u], m_pe[u], m_ovr[u]});
      end
    end
  end

  // Sends one frame with ready=1 and pins the hand-computed result at T0+OS/2+10*OS.
  task automatic frame_check(input string name, input int u, input logic [8:0] d,
                             input bit bad_par, input bit bad_stop, input logic [8:0] exp_d,
                             input logic exp_fe, input logic exp_pe);
    int n;
    @(negedge clk);
    n = cyc;
    fork
      send(u, mk(u, d, bad_par, bad_stop), 0);
      begin
        wait_to(n + 170);
        check({name, "_valid_early"}, 32'(dut_valid(u)), 32'd0);
        wait_to(n + 171);
        check({name, "_valid"}, 32'(dut_valid(u)), 32'd1);
        check({name, "_data"}, 32'(dut_data(u)), 32'(exp_d));
        check({name, "_flags"}, {30'd0, dut_fe(u), dut_pe(u)}, {30'd0, exp_fe, exp_pe});
      end
    join
    repeat (20) @(negedge clk);
  endtask

  // Reset pulse lands in data bit 3, which is 1 along with every later bit.
  task automatic reset_abort(input string name, input int u, input logic [8:0] d);
    int n;
    @(negedge clk);
    n = cyc;
    fork
      send(u, mk(u, d, 1'b0, 1'b0), 0);
      begin
        wait_to(n + 69);
        set_rst(u, 1'b0);
        @(negedge clk);
        set_rst(u, 1'b1);
        wait_to(n + 171);
        check({name, "_no_valid"}, 32'(dut_valid(u)), 32'd0);
      end
    join
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n0    = 1'b0;
    rst_n1    = 1'b0;
    if0.rx    = 1'b1;
    if1.rx    = 1'b1;
    if0.ready = 1'b1;
    if1.ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", {30'd0, dut_valid(0), dut_valid(1)}, 32'd0);
    check("reset_data", {dut_data(0), dut_data(1)}, 32'd0);
    check("reset_flags", {26'd0, dut_fe(0), dut_pe(0), dut_ovr(0), dut_fe(1), dut_pe(1),
                          dut_ovr(1)}, 32'd0);
    cmp_en = 1'b1;
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    repeat (5) @(negedge clk);

    frame_check("a5_good", 0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0);
    frame_check("a5_badpar", 0, 9'h0A5, 1'b1, 1'b0, 9'h0A5, 1'b0, 1'b1);

    // short low pulse is rejected at the start sample
    if0.rx = 1'b0;
    repeat (4) @(negedge clk);
    if0.rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_valid", 32'(dut_valid(0)), 32'd0);
    frame_check("3c_after_glitch", 0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0);

    frame_check("5a_badstop", 0, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b1, 1'b0);

    // break: line low for 30 bit times yields exactly one word
    @(negedge clk);
    n = cyc;
    fork
      send(0, 16'h0000, 30 * OS - nsamp(0) * OS);
      begin
        wait_to(n + 171);
        check("break_valid", 32'(dut_valid(0)), 32'd1);
        check("break_word", {dut_data(0), 21'd0, dut_fe(0), dut_pe(0)}, {9'h000, 21'd0, 2'b10});
        wait_to(n + 470);
        check("break_quiet", 32'(dut_valid(0)), 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    frame_check("96_after_break", 0, 9'h096, 1'b0, 1'b0, 9'h096, 1'b0, 1'b0);

    // overrun: two words with the consumer stalled
    if0.ready = 1'b0;
    send(0, mk(0, 9'h011, 1'b0, 1'b0), 0);
    repeat (20) @(negedge clk);
    check("ovr_first", {dut_valid(0), dut_data(0), dut_ovr(0)}, {1'b1, 9'h011, 1'b0});
    send(0, mk(0, 9'h022, 1'b0, 1'b0), 0);
    check("ovr_second", {dut_valid(0), dut_data(0), dut_ovr(0)}, {1'b1, 9'h022, 1'b1});
    if0.ready = 1'b1;
    @(negedge clk);
    if0.ready = 1'b0;
    check("ovr_accepted", {dut_valid(0), dut_ovr(0)}, 2'b00);
    repeat (20) @(negedge clk);

    // handshake on the same edge a new word completes
    send(0, mk(0, 9'h033, 1'b0, 1'b0), 0);
    repeat (20) @(negedge clk);
    n = cyc;
    fork
      send(0, mk(0, 9'h044, 1'b0, 1'b0), 0);
      begin
        wait_to(n + 170);
        if0.ready = 1'b1;
        wait_to(n + 171);
        check("same_edge", {dut_valid(0), dut_data(0), dut_ovr(0)}, {1'b1, 9'h044, 1'b0});
        wait_to(n + 172);
        check("same_edge_drain", 32'(dut_valid(0)), 32'd0);
      end
    join
    repeat (20) @(negedge clk);

    reset_abort("rst_u0", 0, 9'h0FB);
    frame_check("c3_u0", 0, 9'h0C3, 1'b0, 1'b0, 9'h0C3, 1'b0, 1'b0);
    frame_check("u1_good", 1, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0);
    reset_abort("rst_u1", 1, 9'h07B);
    frame_check("c3_u1", 1, 9'h043, 1'b0, 1'b0, 9'h043, 1'b0, 1'b0);
    frame_check("u1_badpar", 1, 9'h043, 1'b1, 1'b0, 9'h043, 1'b0, 1'b1);
    frame_check("u1_badstop", 1, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL provide parameter OVERSAMPLE, default 16, clk cycles per bit, even, legal range 4..256.
REQ-003 SHALL provide parameter PARITY, default 0, 0=none, 1=odd, 2=even.
REQ-004 SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL provide port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL provide port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL provide port rx  in  1  asynchronous serial line, idle high, LSB first.
REQ-008 SHALL provide port data  out  DATA_BITS  last received word.
REQ-009 SHALL provide port valid  out  1  data/error flags hold a word not yet accepted.
REQ-010 SHALL provide port ready  in  1  consumer accepts the word when valid&&ready.
REQ-011 SHALL provide port frame_err  out  1  a stop bit of the current word sampled 0.
REQ-012 SHALL provide port parity_err  out  1  parity mismatch on the current word; always 0 when PARITY=0.
REQ-013 SHALL provide port overrun  out  1  one or more words were lost before the current word was accepted.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-016 SHALL, in IDLE and armed, enter START on the first edge with rxs==0 (edge T0) and clear the bit-timing counter.
REQ-017 SHALL take sample k (k=0 start, then data, parity, stop) on edge T0+OVERSAMPLE/2+k*OVERSAMPLE.
REQ-018 SHALL return to IDLE with no output when the start sample is 1 (glitch rejection).
REQ-019 SHALL shift data samples LSB first; bit counter width ceil(log2(DATA_BITS+1)).
REQ-020 SHALL compute parity as XOR of the data bits (odd: XOR equals the inverse of the parity bit).
REQ-021 SHALL set frame_err when any of the STOP_BITS samples is 0.
REQ-022 SHALL, at the last stop sample, load data, frame_err and parity_err, set valid=1, and enter IDLE; outputs are visible the cycle after that edge.
REQ-023 SHALL, after a frame with frame_err=1 and data all zero (break), stay disarmed in IDLE until rxs==1 is seen.
REQ-024 SHALL clear valid and overrun on the edge where valid&&ready is true with no word completing.
REQ-025 SHALL, when a word completes while valid&&!ready, overwrite data and flags with the new word and set overrun=1.
REQ-026 SHALL, when a word completes on the same edge as valid&&ready, load the new word, keep valid=1, and leave overrun=0.
REQ-027 SHALL keep data and flags stable while valid=1 and no new word completes.
REQ-028 SHALL ignore ready while valid=0.

Reset
REQ-029 SHALL, while rst_n==0 on a clock edge, set state=IDLE (armed), the synchronizer flops to 1, counters to 0, and data, valid, frame_err, parity_err and overrun to 0.
REQ-030 SHALL abort a frame in progress on reset without producing valid; the first frame after release is received normally.

Verification
REQ-031 SHALL cover: DATA_BITS=8, OVERSAMPLE=16, PARITY=2, STOP_BITS=1; send 0xA5 with parity 0 -> data=0xA5, valid=1, both errors 0, valid at T0+8+10*16+1.
REQ-032 SHALL cover: the same configuration, 0xA5 with parity bit 1 -> data=0xA5, parity_err=1, frame_err=0.
REQ-033 SHALL cover: rx low for 4 clk then high -> valid stays 0, state returns to IDLE, the next frame 0x3C is received correctly.
REQ-034 SHALL cover: 0x5A with stop bit 0 -> frame_err=1; rx held low for 30 bit times -> one break word (data=0x00, frame_err=1), then no further words until rx returns high.
REQ-035 SHALL cover: ready=0 while sending 0x11 then 0x22 -> data=0x22, overrun=1; then ready=1 for one cycle -> valid=0, overrun=0.
REQ-036 SHALL cover: rst_n=0 for 1 cycle during data bit 3 -> no valid; a following 0xC3 frame is received correctly; repeat with PARITY=1, STOP_BITS=2, DATA_BITS=7.
